// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: width helpers, FSM states, 1/K constant and the 32-bit atan table
// (2^32 = 2*pi) used by both the vectoring and the rotation CORDIC.
package cordic_pkg;

    localparam int unsigned CNT_W      = 5;
    localparam int unsigned ATAN_W     = 32;
    localparam int unsigned INV_K      = 159188;
    localparam int unsigned INV_K_FRAC = 18;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        DONE,
        GAIN
    } state_e;

    function automatic int unsigned cordic_wr(input int unsigned in_width, input int unsigned extra);
        return in_width + extra + 2;
    endfunction

    function automatic int unsigned cordic_wz(input int unsigned in_width, input int unsigned extra);
        return in_width + extra;
    endfunction

    function automatic int unsigned cordic_stg(input int unsigned in_width, input int unsigned extra);
        return in_width + extra - 1;
    endfunction

    // atan(2^-n) scaled so that 2^32 is one full turn
    function automatic logic [ATAN_W-1:0] atan32(input logic [CNT_W-1:0] n);
        case (n)
            5'd0:    return 32'd536870912;
            5'd1:    return 32'd316933406;
            5'd2:    return 32'd167458907;
            5'd3:    return 32'd85004756;
            5'd4:    return 32'd42667331;
            5'd5:    return 32'd21354465;
            5'd6:    return 32'd10679838;
            5'd7:    return 32'd5340245;
            5'd8:    return 32'd2670163;
            5'd9:    return 32'd1335087;
            5'd10:   return 32'd667544;
            5'd11:   return 32'd333772;
            5'd12:   return 32'd166886;
            5'd13:   return 32'd83443;
            5'd14:   return 32'd41722;
            5'd15:   return 32'd20861;
            5'd16:   return 32'd10430;
            5'd17:   return 32'd5215;
            5'd18:   return 32'd2608;
            5'd19:   return 32'd1304;
            5'd20:   return 32'd652;
            5'd21:   return 32'd326;
            5'd22:   return 32'd163;
            5'd23:   return 32'd81;
            5'd24:   return 32'd41;
            5'd25:   return 32'd20;
            5'd26:   return 32'd10;
            5'd27:   return 32'd5;
            5'd28:   return 32'd3;
            5'd29:   return 32'd1;
            5'd30:   return 32'd1;
            default: return 32'd0;
        endcase
    endfunction

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational atan lookup: iteration index n -> atan(2^-n) rounded to WZ bits (2^WZ = 2*pi).
module cordic_atan_rom
    import cordic_pkg::*;
#(
    parameter int unsigned WZ = 20
) (
    input  logic [CNT_W-1:0] n,
    output logic [WZ-1:0]    atan_c
);

    localparam int unsigned        SH   = ATAN_W - WZ;
    localparam logic [ATAN_W:0]    HALF = ((ATAN_W + 1)'(1) << SH) >> 1;

    logic [ATAN_W:0] rounded;

    always_comb begin
        rounded = {1'b0, atan32(n)} + HALF;
        atan_c  = WZ'(rounded >> SH);
    end

endmodule

// File: rtl/cordic_vector_iter.sv
// Folded vectoring-mode CORDIC: one (I,Q) sample -> magnitude and phase every STG+1 clocks.
// Define CORDIC_GAIN_COMP_EN to add a GAIN state that scales the magnitude by 1/K.
module cordic_vector_iter
    import cordic_pkg::*;
#(
    parameter  int unsigned IN_WIDTH   = 16,
    parameter  int unsigned EXTRA_BITS = 4,
    localparam int unsigned WR         = cordic_wr(IN_WIDTH, EXTRA_BITS),
    localparam int unsigned WZ         = cordic_wz(IN_WIDTH, EXTRA_BITS)
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IN_WIDTH-1:0] in_I,
    input  logic [IN_WIDTH-1:0] in_Q,
    output logic                out_valid,
    output logic [WR-1:0]       out_mag,
    output logic [WZ-1:0]       out_phase
);

    localparam int unsigned          STG       = cordic_stg(IN_WIDTH, EXTRA_BITS);
    localparam logic [CNT_W-1:0]     N_LAST    = CNT_W'(STG - 2);
    localparam logic signed [WZ-1:0] Z_QUARTER = WZ'(1) << (WZ - 2);

    state_e                state, state_d;
    logic                  load, iter_en, emit;
    logic [CNT_W-1:0]      n;
    logic signed [WR-1:0]  x, y;
    logic signed [WZ-1:0]  z;
    logic                  zero_flag;
    logic [WZ-1:0]         atan_c;
    logic signed [WR-1:0]  ext_i, ext_q;
    logic signed [WR-1:0]  x_sr, y_sr, x_step, y_step;
    logic                  x_rb, y_rb;
    logic [WR-1:0]         mag_c;

    cordic_atan_rom #(.WZ(WZ)) u_atan (
        .n      (n),
        .atan_c (atan_c)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state    <= IDLE;
            in_ready <= 1'b0;
        end else begin
            state    <= state_d;
            in_ready <= (state_d == IDLE);
        end
    end

    always_comb begin
        state_d = state;
        load    = 1'b0;
        iter_en = 1'b0;
        emit    = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    load    = 1'b1;
                    state_d = ITER;
                end
            end
            ITER: begin
                iter_en = 1'b1;
                if (n == N_LAST) state_d = DONE;
            end
            DONE: begin
`ifdef CORDIC_GAIN_COMP_EN
                state_d = GAIN;
`else
                emit    = 1'b1;
                state_d = IDLE;
`endif
            end
            GAIN: begin
`ifdef CORDIC_GAIN_COMP_EN
                emit    = 1'b1;
`endif
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Input scaling plus rounded arithmetic shifts (round half up via the last bit shifted out)
    always_comb begin
        ext_i  = WR'($signed(in_I)) <<< EXTRA_BITS;
        ext_q  = WR'($signed(in_Q)) <<< EXTRA_BITS;
        x_sr   = x >>> n;
        y_sr   = y >>> n;
        x_rb   = (n != '0) && (((x >> (n - CNT_W'(1))) & WR'(1)) != '0);
        y_rb   = (n != '0) && (((y >> (n - CNT_W'(1))) & WR'(1)) != '0);
        x_step = x_sr + WR'(x_rb);
        y_step = y_sr + WR'(y_rb);
    end

    // Pre-rotation by -/+ pi/2 puts the vector in the right half-plane before iterating
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            x         <= '0;
            y         <= '0;
            z         <= '0;
            n         <= '0;
            zero_flag <= 1'b0;
        end else if (load) begin
            if (!in_Q[IN_WIDTH-1]) begin
                x <= ext_q;
                y <= -ext_i;
                z <= Z_QUARTER;
            end else begin
                x <= -ext_q;
                y <= ext_i;
                z <= -Z_QUARTER;
            end
            zero_flag <= (in_I == '0) && (in_Q == '0);
            n         <= '0;
        end else if (iter_en) begin
            if (!y[WR-1]) begin
                x <= x + y_step;
                y <= y - x_step;
                z <= z + atan_c;
            end else begin
                x <= x - y_step;
                y <= y + x_step;
                z <= z - atan_c;
            end
            n <= n + CNT_W'(1);
        end
    end

`ifdef CORDIC_GAIN_COMP_EN
    localparam int unsigned              PW        = WR + INV_K_FRAC;
    localparam logic [WR+INV_K_FRAC-1:0] PROD_HALF = PW'(1) << (INV_K_FRAC - 1);

    logic [PW-1:0] prod;

    always_comb begin
        prod  = PW'($unsigned(x)) * PW'(INV_K);
        mag_c = WR'((prod + PROD_HALF) >> INV_K_FRAC);
    end
`else
    always_comb begin
        mag_c = $unsigned(x);
    end
`endif

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_mag   <= '0;
            out_phase <= '0;
        end else begin
            out_valid <= emit;
            if (emit) begin
                out_mag   <= mag_c;
                out_phase <= zero_flag ? '0 : z;
            end
        end
    end

endmodule

// File: tb/tb_cordic_vector_iter.sv
// Scoreboard bench for cordic_vector_iter (IN_WIDTH=16, EXTRA_BITS=4): directed corners,
// random vectors, back-to-back throughput, output hold and mid-flight reset.
module tb_cordic_vector_iter;

    localparam int unsigned WR = 22;
    localparam int unsigned WZ = 20;
    localparam int unsigned STG = 19;
`ifdef CORDIC_GAIN_COMP_EN
    localparam longint LAT = STG + 1;
`else
    localparam longint LAT = STG;
`endif
    localparam real PI = 3.14159265358979323846;

    typedef struct {
        longint mag;
        longint ph;
        longint mtol;
        longint ptol;
        longint tx;
    } exp_t;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic [15:0]   in_i, in_q;
    logic          out_valid;
    logic [WR-1:0] out_mag;
    logic [WZ-1:0] out_phase;

    exp_t   sb[$];
    int     n_vec = 0;
    int     n_err = 0;
    longint cyc = 0;
    longint last_tx = -1;
    real    kgain;
    bit     prev_ov = 1'b0;
    bit     have_out = 1'b0;
    longint last_mag, last_ph;

    cordic_vector_iter dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_I      (in_i),
        .in_Q      (in_q),
        .out_valid (out_valid),
        .out_mag   (out_mag),
        .out_phase (out_phase)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input longint obs, input longint exp, input longint tol);
        longint d;
        n_vec++;
        d = (obs > exp) ? obs - exp : exp - obs;
        if (d > tol) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d) at cycle %0d", tag, obs, exp, tol, cyc);
        end
    endtask

    function automatic exp_t model(input int i, input int q, input longint mtol, input longint ptol);
        exp_t   e;
        real    ri, rq, ph;
        ri = real'(i);
        rq = real'(q);
        e.mag = longint'($sqrt(ri * ri + rq * rq) * 16.0 * kgain);
        if (i == 0 && q == 0) begin
            e.ph = 0;
        end else begin
            ph   = $atan2(rq, ri) * 1048576.0 / (2.0 * PI);
            e.ph = longint'(ph);
            if (e.ph >= 524288) e.ph -= 1048576;
        end
        e.mtol = mtol;
        e.ptol = ptol;
        e.tx   = 0;
        return e;
    endfunction

    // Present one sample and hold until it is accepted; called just after a falling edge
    task automatic send(input int i, input int q, input longint mtol, input longint ptol, input bit b2b);
        exp_t e;
        bit   done = 1'b0;
        in_i     = 16'(i);
        in_q     = 16'(q);
        in_valid = 1'b1;
        for (int k = 0; k < 100 && !done; k++) begin
            if (in_ready) begin
                e    = model(i, q, mtol, ptol);
                e.tx = cyc;
                sb.push_back(e);
                if (b2b && last_tx >= 0) check("throughput", cyc - last_tx, LAT + 1, 0);
                last_tx = cyc;
                done = 1'b1;
            end
            @(negedge clock);
        end
        if (!done) check("accept_timeout", 0, 1, 0);
        else check("busy_after_accept", longint'(in_ready), 0, 0);
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && sb.size() != 0; k++) @(negedge clock);
        check("drain", sb.size(), 0, 0);
    endtask

    always @(negedge clock) begin
        exp_t        e;
        logic [19:0] dw;
        if (!reset_n) begin
            have_out = 1'b0;
        end else if (out_valid) begin
            check("pulse_width", longint'(prev_ov), 0, 0);
            if (sb.size() == 0) begin
                check("unexpected_out", 1, 0, 0);
            end else begin
                e  = sb.pop_front();
                check("mag", longint'(out_mag), e.mag, e.mtol);
                dw = 20'(longint'($signed(out_phase)) - e.ph);
                check("phase", e.ph + longint'($signed(dw)), e.ph, e.ptol);
                check("latency", cyc - e.tx, LAT + 1, 0);
            end
            have_out = 1'b1;
            last_mag = longint'(out_mag);
            last_ph  = longint'(out_phase);
        end else if (have_out) begin
            check("hold", (longint'(out_mag) << 20) | longint'(out_phase), (last_mag << 20) | last_ph, 0);
        end
        prev_ov = out_valid;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int i, q, cnt;
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_i     = '0;
        in_q     = '0;
        kgain    = 1.0;
        for (int k = 0; k <= int'(STG) - 2; k++) kgain *= $sqrt(1.0 + 2.0 ** (-2.0 * k));
`ifdef CORDIC_GAIN_COMP_EN
        kgain *= 159188.0 / 262144.0;
`endif
        repeat (3) @(negedge clock);
        check("rst_in_ready", longint'(in_ready), 0, 0);
        check("rst_out_valid", longint'(out_valid), 0, 0);
        check("rst_out_mag", longint'(out_mag), 0, 0);
        check("rst_out_phase", longint'(out_phase), 0, 0);
        reset_n = 1'b1;
        @(negedge clock);
        check("ready_after_rst", longint'(in_ready), 1, 0);

        // Directed corners, with idle gaps between samples
        send(16384, 0, 4, 2, 1'b0);       in_valid = 1'b0; drain();
        send(0, 16384, 8, 2, 1'b0);       in_valid = 1'b0; drain();
        send(0, -16384, 8, 2, 1'b0);      in_valid = 1'b0; drain();
        send(-16384, 0, 8, 2, 1'b0);      in_valid = 1'b0; drain();
        send(-32768, -32768, 8, 2, 1'b0); in_valid = 1'b0; drain();
        send(0, 0, 0, 0, 1'b0);           in_valid = 1'b0; drain();
        send(32767, -32768, 8, 3, 1'b0);  in_valid = 1'b0; repeat (4) @(negedge clock);

        // in_valid held high: one transfer every LAT+1 clocks
        last_tx = -1;
        send(12000, 5000, 8, 3, 1'b1);
        send(-7000, 20000, 8, 3, 1'b1);
        send(-30000, -1000, 8, 3, 1'b1);
        send(4096, -4096, 8, 3, 1'b1);
        in_valid = 1'b0;
        drain();

        for (int r = 0; r < 16; r++) begin
            i = int'($urandom_range(0, 65535)) - 32768;
            q = int'($urandom_range(0, 65535)) - 32768;
            if ((i < 0 ? -i : i) + (q < 0 ? -q : q) < 4096) i = 4096;
            send(i, q, 8, 4, 1'b0);
            in_valid = 1'b0;
        end
        drain();

        // Reset while iteration 7 is pending: the sample is dropped
        send(10000, 10000, 8, 3, 1'b0);
        in_valid = 1'b0;
        repeat (7) @(negedge clock);
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        sb.delete();
        reset_n = 1'b1;
        @(negedge clock);
        check("ready_after_midrst", longint'(in_ready), 1, 0);
        check("mag_after_midrst", longint'(out_mag), 0, 0);
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (out_valid) cnt++;
            @(negedge clock);
        end
        check("no_out_after_midrst", cnt, 0, 0);

        send(-16384, 16384, 8, 3, 1'b0);
        in_valid = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
